// File: rtl/multiplexer_n_to_1_reg.sv
// N-input registered multiplexer with valid/ready handshakes.
// Direct-select or round-robin arbitration feeding one output register.
module multiplexer_n_to_1_reg #(
  parameter int WIDTH = 3,
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               MODE,
  input  logic [SEL_W-1:0]   S,
  input  logic [N*WIDTH-1:0] I,
  input  logic [N-1:0]       V,
  output logic [N-1:0]       GNT,
  output logic [WIDTH-1:0]   Y,
  output logic               YV,
  input  logic               YR,
  output logic [SEL_W-1:0]   YSEL
);

  logic [WIDTH-1:0] y_q;
  logic             yv_q;
  logic [SEL_W-1:0] ysel_q;
  logic [SEL_W-1:0] ptr_q;

  logic             free;
  logic             hit;
  logic             accept;
  logic [SEL_W-1:0] k;
  logic [SEL_W-1:0] k_nxt;
  logic [WIDTH-1:0] d_sel;
  logic [N-1:0]     gnt;

  assign free = !yv_q || YR;

  // Candidate search. Out-of-range S never matches any j < N.
  // Round-robin: first pass covers PTR..N-1, second wraps 0..PTR-1.
  always_comb begin
    hit = 1'b0;
    k   = '0;
    if (!MODE) begin
      for (int j = 0; j < N; j++) begin
        if (S == SEL_W'(j) && V[j]) begin
          hit = 1'b1;
          k   = SEL_W'(j);
        end
      end
    end else begin
      for (int j = 0; j < N; j++) begin
        if (!hit && V[j] && SEL_W'(j) >= ptr_q) begin
          hit = 1'b1;
          k   = SEL_W'(j);
        end
      end
      for (int j = 0; j < N; j++) begin
        if (!hit && V[j] && SEL_W'(j) < ptr_q) begin
          hit = 1'b1;
          k   = SEL_W'(j);
        end
      end
    end
  end

  assign accept = !RST && free && hit;

  always_comb begin
    gnt   = '0;
    d_sel = '0;
    for (int j = 0; j < N; j++) begin
      if (k == SEL_W'(j)) begin
        gnt[j] = accept;
        d_sel  = I[j*WIDTH +: WIDTH];
      end
    end
  end

  // Wrap explicitly so non-power-of-two N never yields PTR >= N.
  assign k_nxt = (k == SEL_W'(N-1)) ? '0 : k + SEL_W'(1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      y_q    <= '0;
      yv_q   <= 1'b0;
      ysel_q <= '0;
      ptr_q  <= '0;
    end else if (accept) begin
      y_q    <= d_sel;
      yv_q   <= 1'b1;
      ysel_q <= k;
      if (MODE) begin
        ptr_q <= k_nxt;
      end
    end else if (YR) begin
      yv_q <= 1'b0;
    end
  end

  assign GNT  = gnt;
  assign Y    = y_q;
  assign YV   = yv_q;
  assign YSEL = ysel_q;

endmodule

// File: tb/tb_multiplexer_n_to_1_reg.sv
// Scoreboard bench: N=4 and N=3 instances share stimulus,
// a reference model predicts grants and queued outputs.
module tb_multiplexer_n_to_1_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [1:0]  s;
  logic [11:0] i;
  logic [3:0]  v;
  logic        yr;

  logic [3:0]  gnt4;
  logic [2:0]  y4;
  logic        yv4;
  logic [1:0]  ysel4;
  logic [2:0]  gnt3;
  logic [2:0]  y3;
  logic        yv3;
  logic [1:0]  ysel3;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int y;
    int sel;
  } item_t;

  item_t q4[$];
  item_t q3[$];
  int    m_yv[2];
  int    m_ptr[2];
  int    last_rst;

  always #5 clk = ~clk;

  multiplexer_n_to_1_reg #(.WIDTH(3), .N(4), .SEL_W(2)) dut4 (
    .CLK(clk), .RST(rst), .MODE(mode), .S(s), .I(i), .V(v),
    .GNT(gnt4), .Y(y4), .YV(yv4), .YR(yr), .YSEL(ysel4)
  );

  multiplexer_n_to_1_reg #(.WIDTH(3), .N(3), .SEL_W(2)) dut3 (
    .CLK(clk), .RST(rst), .MODE(mode), .S(s), .I(i[8:0]), .V(v[2:0]),
    .GNT(gnt3), .Y(y3), .YV(yv3), .YR(yr), .YSEL(ysel3)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference choice: index of input to grant, or -1.
  function automatic int pick(int n, logic md, int sv,
                              logic [3:0] vv, int ptr);
    if (!md) begin
      if (sv < n && vv[sv]) return sv;
      return -1;
    end
    for (int off = 0; off < n; off++) begin
      int idx;
      idx = (ptr + off) % n;
      if (vv[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_inst(input int inst);
    int n, k, eg;
    bit fr;
    logic [31:0] ag, ayv, ay, asel;
    item_t it;
    n    = (inst == 0) ? 4 : 3;
    ag   = (inst == 0) ? 32'(gnt4) : 32'(gnt3);
    ayv  = (inst == 0) ? 32'(yv4) : 32'(yv3);
    ay   = (inst == 0) ? 32'(y4) : 32'(y3);
    asel = (inst == 0) ? 32'(ysel4) : 32'(ysel3);
    fr = (m_yv[inst] == 0) || yr;
    k  = (rst || !fr) ? -1 : pick(n, mode, int'(s), v, m_ptr[inst]);
    eg = (k >= 0) ? (1 << k) : 0;
    chk($sformatf("gnt_n%0d", n), ag, eg);
    chk($sformatf("yv_n%0d", n), ayv, m_yv[inst]);
    if (last_rst != 0) begin
      chk($sformatf("rst_y_n%0d", n), ay, 0);
      chk($sformatf("rst_ysel_n%0d", n), asel, 0);
    end
    if (rst) begin
      m_yv[inst]  = 0;
      m_ptr[inst] = 0;
      if (inst == 0) q4.delete();
      else q3.delete();
    end else if (k >= 0) begin
      it.y   = int'(i >> (3 * k)) & 7;
      it.sel = k;
      if (inst == 0) q4.push_back(it);
      else q3.push_back(it);
      m_yv[inst] = 1;
      if (mode) m_ptr[inst] = (k + 1) % n;
    end else if (yr) begin
      m_yv[inst] = 0;
    end
  endtask

  task automatic cyc(input logic r, input logic md, input logic [1:0] sv,
                     input logic [3:0] vv, input logic [11:0] iv,
                     input logic yrv);
    @(negedge clk);
    rst  = r;
    mode = md;
    s    = sv;
    v    = vv;
    i    = iv;
    yr   = yrv;
    #1;
    model_inst(0);
    model_inst(1);
    last_rst = int'(r);
  endtask

  task automatic pop_chk(input int inst);
    item_t e;
    int n;
    n = (inst == 0) ? 4 : 3;
    if ((inst == 0 ? q4.size() : q3.size()) == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_out_n%0d: got output, expected none", n);
    end else begin
      e = (inst == 0) ? q4.pop_front() : q3.pop_front();
      chk($sformatf("y_n%0d", n),
          (inst == 0) ? 32'(y4) : 32'(y3), e.y);
      chk($sformatf("ysel_n%0d", n),
          (inst == 0) ? 32'(ysel4) : 32'(ysel3), e.sel);
    end
  endtask

  // Monitor: an item is delivered when YV && YR at the coming edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst === 1'b0 && yr === 1'b1) begin
        if (yv4 === 1'b1) pop_chk(0);
        if (yv3 === 1'b1) pop_chk(1);
      end
    end
  end

  initial begin
    m_yv     = '{0, 0};
    m_ptr    = '{0, 0};
    last_rst = 0;
    rst  = 1'b1;
    mode = 1'b0;
    s    = '0;
    v    = '0;
    i    = '0;
    yr   = 1'b1;
    @(posedge clk);

    cyc(1, 0, 0, 4'b0000, 12'h000, 1);
    cyc(1, 0, 0, 4'b0000, 12'h000, 1);
    cyc(0, 0, 1, 4'b0010, 12'h028, 1);
    cyc(0, 0, 1, 4'b0000, 12'h028, 1);

    cyc(0, 0, 0, 4'b0011, 12'h011, 1);
    cyc(0, 0, 1, 4'b0011, 12'h011, 1);
    cyc(0, 0, 0, 4'b0011, 12'h023, 1);
    cyc(0, 0, 1, 4'b0011, 12'h023, 1);

    cyc(0, 0, 2, 4'b0100, 12'h180, 1);
    for (int c = 0; c < 3; c++) cyc(0, 0, 2, 4'b1111, 12'h5a7, 0);
    cyc(0, 0, 2, 4'b1111, 12'h5a7, 1);
    cyc(0, 0, 2, 4'b0000, 12'h5a7, 1);

    for (int c = 0; c < 6; c++) cyc(0, 1, 0, 4'b1011, 12'hc35, 1);
    cyc(0, 1, 0, 4'b0000, 12'hc35, 1);
    cyc(0, 1, 0, 4'b0000, 12'hc35, 1);

    cyc(0, 0, 3, 4'b0111, 12'h1f6, 1);
    cyc(0, 0, 3, 4'b0111, 12'h1f6, 1);
    for (int c = 0; c < 3; c++) cyc(0, 1, 3, 4'b0111, 12'h1f6, 1);
    cyc(0, 1, 3, 4'b0000, 12'h1f6, 1);

    cyc(0, 0, 1, 4'b0010, 12'h038, 1);
    cyc(0, 0, 1, 4'b0000, 12'h038, 0);
    cyc(1, 0, 1, 4'b0000, 12'h038, 0);
    cyc(0, 0, 1, 4'b0000, 12'h038, 1);
    cyc(0, 1, 0, 4'b0100, 12'h1c0, 1);

    for (int c = 0; c < 400; c++) begin
      cyc(($urandom % 50) == 0, 1'($urandom), 2'($urandom),
          4'($urandom), 12'($urandom), ($urandom % 4) != 0);
    end

    for (int c = 0; c < 3; c++) cyc(0, 0, 0, 4'b0000, 12'h000, 1);
    chk("drain_q_n4", q4.size(), 0);
    chk("drain_q_n3", q3.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
